// File: rtl/mem_controller_rr.sv
// mem_controller_rr
//   Arbitrates read/write requests from NUM_CONSUMERS requesters onto
//   NUM_CHANNELS memory channels. Grants are round-robin fair. Each channel
//   runs its own small FSM and relays the response back to the consumer it
//   serves. With WRITE_ENABLE=0 the write path is inert, which suits a
//   read-only program-memory instance.
//
// Ports (per-consumer / per-channel buses are flattened, slot k = [k*W +: W]):
//   clk                     in   rising-edge clock
//   reset                   in   asynchronous, active-low
//   consumer_read_valid     in   read request, held until ready is seen
//   consumer_read_address   in   read address per consumer
//   consumer_read_ready     out  read data valid, held until valid drops
//   consumer_read_data      out  read data per consumer
//   consumer_write_valid    in   write request, held until ready is seen
//   consumer_write_address  in   write address per consumer
//   consumer_write_data     in   write data per consumer
//   consumer_write_ready    out  write done, held until valid drops
//   mem_read_valid          out  read request per channel
//   mem_read_address        out  read address per channel
//   mem_read_ready          in   read data returned per channel
//   mem_read_data           in   read data per channel
//   mem_write_valid         out  write request per channel
//   mem_write_address       out  write address per channel
//   mem_write_data          out  write data per channel
//   mem_write_ready         in   write accepted per channel
//   channel_busy            out  1 while the channel is not IDLE

module mem_controller_rr #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter bit WRITE_ENABLE  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]              mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]              mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]              mem_write_ready,
    output logic [NUM_CHANNELS-1:0]              channel_busy
);

    localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_RELAY = 3'd2,
        WR_WAIT  = 3'd3,
        WR_RELAY = 3'd4
    } chan_state_t;

    // Per-channel state
    chan_state_t          state     [NUM_CHANNELS];
    logic [IDX_BITS-1:0]  serving   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] rd_addr_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] wr_addr_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wr_data_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] mem_rd_data_in [NUM_CHANNELS];

    // Per-consumer state
    logic [NUM_CONSUMERS-1:0] claimed;
    logic [DATA_BITS-1:0]     rd_data_q  [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     rd_addr_in [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     wr_addr_in [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     wr_data_in [NUM_CONSUMERS];

    logic [IDX_BITS-1:0] rr_ptr;

    // Arbitration results for this cycle
    logic [NUM_CHANNELS-1:0]  grant;
    logic [NUM_CHANNELS-1:0]  grant_is_read;
    logic [IDX_BITS-1:0]      grant_idx [NUM_CHANNELS];
    logic [IDX_BITS-1:0]      rr_next;
    logic [NUM_CONSUMERS-1:0] write_req;

    // A read-only instance never sees write requests at all.
    assign write_req = WRITE_ENABLE ? consumer_write_valid : '0;

    for (genvar k = 0; k < NUM_CONSUMERS; k++) begin : g_consumer
        assign rd_addr_in[k] = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
        assign wr_addr_in[k] = consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
        assign wr_data_in[k] = consumer_write_data[k*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[k*DATA_BITS +: DATA_BITS] = rd_data_q[k];
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
        assign mem_rd_data_in[ch] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
        assign mem_read_address[ch*ADDR_BITS +: ADDR_BITS]  = rd_addr_q[ch];
        assign mem_write_address[ch*ADDR_BITS +: ADDR_BITS] = wr_addr_q[ch];
        assign mem_write_data[ch*DATA_BITS +: DATA_BITS]    = wr_data_q[ch];
        assign channel_busy[ch] = (state[ch] != IDLE);
    end

    // Round-robin arbitration over IDLE channels in ascending index. The
    // claim vector starts from the registered claims, so a consumer released
    // this cycle stays unavailable until the next one.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        int                       cand;
        logic [IDX_BITS-1:0]      cand_idx;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        taken    = claimed;
        rr_next  = rr_ptr;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant[ch]         = 1'b0;
            grant_is_read[ch] = 1'b0;
            grant_idx[ch]     = '0;
            found             = 1'b0;
            if (state[ch] == IDLE) begin
                for (int off = 0; off < NUM_CONSUMERS; off++) begin
                    cand = int'(rr_ptr) + off;
                    if (cand >= NUM_CONSUMERS) begin
                        cand = cand - NUM_CONSUMERS;
                    end
                    cand_idx = IDX_BITS'(cand);
                    if (!found && !taken[cand_idx] &&
                        (consumer_read_valid[cand_idx] || write_req[cand_idx])) begin
                        found             = 1'b1;
                        grant[ch]         = 1'b1;
                        grant_is_read[ch] = consumer_read_valid[cand_idx];  // read wins
                        grant_idx[ch]     = cand_idx;
                        // NOTE: blocking update of the local copy lets later channels see this claim in the same cycle.
                        taken[cand_idx]   = 1'b1;
                        rr_next = (cand + 1 >= NUM_CONSUMERS) ? '0 : IDX_BITS'(cand + 1);
                    end
                end
            end
        end
    end

    // Channel FSMs, claims and all registered outputs. Releases and grants
    // never touch the same consumer in one cycle, because a grant requires
    // the registered claim to be clear.
    // NOTE: all state here uses non-blocking assignments so every channel sees the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the register arrays are reset element by element because every output must read 0 in reset.
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch]     <= IDLE;
                serving[ch]   <= '0;
                rd_addr_q[ch] <= '0;
                wr_addr_q[ch] <= '0;
                wr_data_q[ch] <= '0;
            end
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                rd_data_q[k] <= '0;
            end
            claimed              <= '0;
            rr_ptr               <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_write_valid      <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    IDLE: begin
                        if (grant[ch]) begin
                            claimed[grant_idx[ch]] <= 1'b1;
                            serving[ch]            <= grant_idx[ch];
                            if (grant_is_read[ch]) begin
                                mem_read_valid[ch] <= 1'b1;
                                rd_addr_q[ch]      <= rd_addr_in[grant_idx[ch]];
                                state[ch]          <= RD_WAIT;
                            end else begin
                                mem_write_valid[ch] <= 1'b1;
                                wr_addr_q[ch]       <= wr_addr_in[grant_idx[ch]];
                                wr_data_q[ch]       <= wr_data_in[grant_idx[ch]];
                                state[ch]           <= WR_WAIT;
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch]               <= 1'b0;
                            rd_data_q[serving[ch]]           <= mem_rd_data_in[ch];
                            consumer_read_ready[serving[ch]] <= 1'b1;
                            state[ch]                        <= RD_RELAY;
                        end
                    end
                    RD_RELAY: begin
                        if (!consumer_read_valid[serving[ch]]) begin
                            consumer_read_ready[serving[ch]] <= 1'b0;
                            claimed[serving[ch]]             <= 1'b0;
                            state[ch]                        <= IDLE;
                        end
                    end
                    WR_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch]               <= 1'b0;
                            consumer_write_ready[serving[ch]] <= 1'b1;
                            state[ch]                         <= WR_RELAY;
                        end
                    end
                    WR_RELAY: begin
                        if (!consumer_write_valid[serving[ch]]) begin
                            consumer_write_ready[serving[ch]] <= 1'b0;
                            claimed[serving[ch]]              <= 1'b0;
                            state[ch]                         <= IDLE;
                        end
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: tb/tb_mem_controller_rr.sv
// Directed bench for mem_controller_rr. u_dut is a 4-consumer / 2-channel
// read-write instance; u_ro is a 4-consumer / 1-channel read-only instance
// used for the fairness and read-only scenarios. Inputs change and outputs
// are sampled on the falling clock edge.

module tb_mem_controller_rr;

    logic clk;
    logic reset;

    // u_dut: 4 consumers, 2 channels, writes enabled
    logic [3:0]  a_crv, a_crr, a_cwv, a_cwr;
    logic [31:0] a_cra, a_cwa;
    logic [63:0] a_crd, a_cwd;
    logic [1:0]  a_mrv, a_mrr, a_mwv, a_mwr, a_busy;
    logic [15:0] a_mra, a_mwa;
    logic [31:0] a_mrd, a_mwd;

    // u_ro: 4 consumers, 1 channel, read-only
    logic [3:0]  b_crv, b_crr, b_cwv, b_cwr;
    logic [31:0] b_cra, b_cwa;
    logic [63:0] b_crd, b_cwd;
    logic [0:0]  b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
    logic [7:0]  b_mra, b_mwa;
    logic [15:0] b_mrd, b_mwd;

    int checks = 0;
    int errors = 0;

    mem_controller_rr #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
        .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr),
        .channel_busy(a_busy)
    );

    mem_controller_rr #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1'b0)
    ) u_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
        .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
        .channel_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_crv = '0; a_cra = '0; a_cwv = '0; a_cwa = '0; a_cwd = '0; a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_crv = '0; b_cra = '0; b_cwv = '0; b_cwa = '0; b_cwd = '0; b_mrr = '0; b_mrd = '0; b_mwr = '0;
        #1 reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({a_crr, a_cwr, a_mrv, a_mwv, a_busy} !== 14'd0) begin
            errors++; $display("FAIL reset_a_ctrl got %b exp 0", {a_crr, a_cwr, a_mrv, a_mwv, a_busy});
        end
        checks++;
        if ({a_crd, a_mra, a_mwa, a_mwd} !== 128'd0) begin
            errors++; $display("FAIL reset_a_data got %h exp 0", {a_crd, a_mra, a_mwa, a_mwd});
        end
        checks++;
        if ({b_crr, b_cwr, b_mrv, b_mwv, b_busy, b_crd, b_mra, b_mwa, b_mwd} !== 107'd0) begin
            errors++; $display("FAIL reset_b got %h exp 0", {b_crr, b_cwr, b_mrv, b_mwv, b_busy, b_crd, b_mra, b_mwa, b_mwd});
        end
        reset = 1'b1;
        tick();
    endtask

    // C0 reads 0x12; memory answers 0xBEEF three cycles after the request.
    task automatic test_single_read();
        a_crv[0] = 1'b1; a_cra[7:0] = 8'h12;
        tick();
        checks++;
        if ({a_mrv, a_busy, a_crr} !== {2'b01, 2'b01, 4'b0000}) begin
            errors++; $display("FAIL rd_grant got mrv=%b busy=%b rr=%b exp 01 01 0000", a_mrv, a_busy, a_crr);
        end
        checks++;
        if (a_mra[7:0] !== 8'h12) begin
            errors++; $display("FAIL rd_addr got %h exp 12", a_mra[7:0]);
        end
        a_cra[7:0] = 8'hFF;  // changes after grant must not reach memory
        repeat (2) tick();
        checks++;
        if (a_mra[7:0] !== 8'h12 || a_mrv !== 2'b01 || a_crr !== 4'b0000) begin
            errors++; $display("FAIL rd_wait got addr=%h mrv=%b rr=%b exp 12 01 0000", a_mra[7:0], a_mrv, a_crr);
        end
        a_mrr = 2'b01; a_mrd[15:0] = 16'hBEEF;
        tick();
        a_mrr = 2'b00; a_mrd = '0;
        checks++;
        if (a_crr !== 4'b0001 || a_crd[15:0] !== 16'hBEEF) begin
            errors++; $display("FAIL rd_resp got rr=%b data=%h exp 0001 beef", a_crr, a_crd[15:0]);
        end
        checks++;
        if (a_mrv !== 2'b00 || a_busy !== 2'b01) begin
            errors++; $display("FAIL rd_relay got mrv=%b busy=%b exp 00 01", a_mrv, a_busy);
        end
        // Memory ready during relay must be ignored.
        a_mrr = 2'b01; a_mrd[15:0] = 16'h0BAD;
        repeat (2) tick();
        a_mrr = 2'b00; a_mrd = '0;
        checks++;
        if (a_crr !== 4'b0001 || a_crd[15:0] !== 16'hBEEF) begin
            errors++; $display("FAIL rd_hold got rr=%b data=%h exp 0001 beef", a_crr, a_crd[15:0]);
        end
        a_crv[0] = 1'b0;
        tick();
        checks++;
        if (a_crr !== 4'b0000 || a_busy !== 2'b00) begin
            errors++; $display("FAIL rd_done got rr=%b busy=%b exp 0000 00", a_crr, a_busy);
        end
    endtask

    // rr_ptr is 1: C1 goes to ch0, C3 to ch1.
    task automatic test_concurrency();
        a_crv = 4'b1010; a_cra = {8'h33, 8'h00, 8'h11, 8'h00};
        tick();
        checks++;
        if (a_mrv !== 2'b11 || a_busy !== 2'b11) begin
            errors++; $display("FAIL conc_grant got mrv=%b busy=%b exp 11 11", a_mrv, a_busy);
        end
        checks++;
        if (a_mra !== {8'h33, 8'h11}) begin
            errors++; $display("FAIL conc_addr got %h exp 3311", a_mra);
        end
        a_mrr = 2'b11; a_mrd = {16'h3333, 16'h1111};
        tick();
        a_mrr = 2'b00; a_mrd = '0;
        checks++;
        if (a_crr !== 4'b1010 || a_crd[31:16] !== 16'h1111 || a_crd[63:48] !== 16'h3333) begin
            errors++; $display("FAIL conc_resp got rr=%b c1=%h c3=%h exp 1010 1111 3333", a_crr, a_crd[31:16], a_crd[63:48]);
        end
        a_crv = 4'b0000;
        tick();
        checks++;
        if (a_crr !== 4'b0000 || a_busy !== 2'b00) begin
            errors++; $display("FAIL conc_done got rr=%b busy=%b exp 0000 00", a_crr, a_busy);
        end
    endtask

    // C0 raises read and write together; the write waits for the read relay.
    task automatic test_read_beats_write();
        a_crv[0] = 1'b1; a_cra[7:0] = 8'h21;
        a_cwv[0] = 1'b1; a_cwa[7:0] = 8'h22; a_cwd[15:0] = 16'hCAFE;
        tick();
        checks++;
        if (a_mrv !== 2'b01 || a_mwv !== 2'b00 || a_mra[7:0] !== 8'h21) begin
            errors++; $display("FAIL rw_first got mrv=%b mwv=%b addr=%h exp 01 00 21", a_mrv, a_mwv, a_mra[7:0]);
        end
        a_mrr = 2'b01; a_mrd[15:0] = 16'h5A5A;
        tick();
        a_mrr = 2'b00; a_mrd = '0;
        checks++;
        if (a_crr !== 4'b0001 || a_crd[15:0] !== 16'h5A5A || a_mwv !== 2'b00) begin
            errors++; $display("FAIL rw_read got rr=%b data=%h mwv=%b exp 0001 5a5a 00", a_crr, a_crd[15:0], a_mwv);
        end
        a_crv[0] = 1'b0;
        tick();
        checks++;
        if (a_crr !== 4'b0000 || a_mwv !== 2'b00 || a_busy !== 2'b00) begin
            errors++; $display("FAIL rw_gap got rr=%b mwv=%b busy=%b exp 0000 00 00", a_crr, a_mwv, a_busy);
        end
        tick();
        checks++;
        if (a_mwv !== 2'b01 || a_mwa[7:0] !== 8'h22 || a_mwd[15:0] !== 16'hCAFE) begin
            errors++; $display("FAIL rw_write got mwv=%b addr=%h data=%h exp 01 22 cafe", a_mwv, a_mwa[7:0], a_mwd[15:0]);
        end
        a_mwr = 2'b01;
        tick();
        a_mwr = 2'b00;
        checks++;
        if (a_cwr !== 4'b0001 || a_mwv !== 2'b00) begin
            errors++; $display("FAIL rw_wdone got wr=%b mwv=%b exp 0001 00", a_cwr, a_mwv);
        end
        a_cwv[0] = 1'b0;
        tick();
        checks++;
        if (a_cwr !== 4'b0000 || a_busy !== 2'b00) begin
            errors++; $display("FAIL rw_release got wr=%b busy=%b exp 0000 00", a_cwr, a_busy);
        end
    endtask

    // Reset while ch0 waits on memory for C2; then a fresh C3 read.
    task automatic test_mid_reset();
        a_crv[2] = 1'b1; a_cra[23:16] = 8'h77;
        tick();
        checks++;
        if (a_mrv !== 2'b01 || a_mra[7:0] !== 8'h77) begin
            errors++; $display("FAIL mr_grant got mrv=%b addr=%h exp 01 77", a_mrv, a_mra[7:0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({a_crr, a_cwr, a_mrv, a_mwv, a_busy, a_mra} !== 30'd0) begin
            errors++; $display("FAIL mr_async got %b exp 0", {a_crr, a_cwr, a_mrv, a_mwv, a_busy, a_mra});
        end
        a_mrr = 2'b01; a_mrd[15:0] = 16'hDEAD;
        a_crv = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        a_mrr = 2'b00; a_mrd = '0;
        checks++;
        if (a_crr !== 4'b0000 || a_busy !== 2'b00 || a_crd !== 64'd0) begin
            errors++; $display("FAIL mr_abandon got rr=%b busy=%b data=%h exp 0000 00 0", a_crr, a_busy, a_crd);
        end
        a_crv[3] = 1'b1; a_cra[31:24] = 8'h99;
        tick();
        checks++;
        if (a_mrv !== 2'b01 || a_mra[7:0] !== 8'h99 || a_busy !== 2'b01) begin
            errors++; $display("FAIL mr_regrant got mrv=%b addr=%h busy=%b exp 01 99 01", a_mrv, a_mra[7:0], a_busy);
        end
        a_mrr = 2'b01; a_mrd[15:0] = 16'h1234;
        tick();
        a_mrr = 2'b00; a_mrd = '0;
        checks++;
        if (a_crr !== 4'b1000 || a_crd[63:48] !== 16'h1234) begin
            errors++; $display("FAIL mr_resp got rr=%b data=%h exp 1000 1234", a_crr, a_crd[63:48]);
        end
        a_crv = 4'b0000;
        tick();
        checks++;
        if (a_busy !== 2'b00 || a_crr !== 4'b0000) begin
            errors++; $display("FAIL mr_done got busy=%b rr=%b exp 00 0000", a_busy, a_crr);
        end
    endtask

    // All four consumers on the one-channel instance keep requesting.
    task automatic test_fairness();
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [1:0]  idx;
        logic [7:0]  exp_addr;
        logic [15:0] got_data;
        b_cra = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_crv = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx      = 2'(order[k]);
            exp_addr = 8'hA0 + {6'd0, idx};
            tick();
            checks++;
            if (b_mrv !== 1'b1 || b_mra !== exp_addr) begin
                errors++; $display("FAIL fair_grant%0d got mrv=%b addr=%h exp 1 %h", k, b_mrv, b_mra, exp_addr);
            end
            b_mrr = 1'b1; b_mrd = 16'h1000 + 16'(k);
            tick();
            b_mrr = 1'b0; b_mrd = '0;
            got_data = 16'(b_crd >> (16 * int'(idx)));
            checks++;
            if (b_crr !== (4'b0001 << idx) || got_data !== 16'h1000 + 16'(k)) begin
                errors++; $display("FAIL fair_resp%0d got rr=%b data=%h exp %b %h", k, b_crr, got_data, 4'b0001 << idx, 16'h1000 + 16'(k));
            end
            b_crv[idx] = 1'b0;
            tick();
            if (k < 4) b_crv[idx] = 1'b1;
            else       b_crv = 4'b0000;
        end
        tick();
        checks++;
        if (b_mrv !== 1'b0 || b_busy !== 1'b0 || b_crr !== 4'b0000) begin
            errors++; $display("FAIL fair_idle got mrv=%b busy=%b rr=%b exp 0 0 0000", b_mrv, b_busy, b_crr);
        end
    endtask

    // The read-only instance must ignore C2's write entirely.
    task automatic test_read_only();
        b_cwv[2] = 1'b1; b_cwa[23:16] = 8'h40; b_cwd[47:32] = 16'h0055;
        b_mwr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (b_mwv !== 1'b0 || b_cwr !== 4'b0000 || b_busy !== 1'b0) begin
                errors++; $display("FAIL ro_cycle%0d got mwv=%b wr=%b busy=%b exp 0 0000 0", i, b_mwv, b_cwr, b_busy);
            end
        end
        checks++;
        if (b_mwa !== 8'h00 || b_mwd !== 16'h0000) begin
            errors++; $display("FAIL ro_bus got addr=%h data=%h exp 00 0000", b_mwa, b_mwd);
        end
        b_cwv = '0; b_mwr = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_concurrency();
        test_read_beats_write();
        test_mid_reset();
        test_fairness();
        test_read_only();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
